// File: rtl/param_cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped read-only parameter cache:
//   - FSM state encoding
//   - default geometry and the widths derived from it
//   - helper functions so a parameterised instance can derive its own
//     tag width, words-per-line and line count from the same formulas
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        REFILL  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Default geometry: 15-bit word address = {3-bit tag, 10-bit index, 2-bit offset}
    localparam int ADDR_W_DEF  = 15;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 10;
    localparam int OFF_W_DEF   = 2;
    localparam int CNT_W_DEF   = 14;

    function automatic int tag_width(input int addr_w, input int index_w, input int off_w);
        return addr_w - index_w - off_w;
    endfunction

    function automatic int words_per_line(input int off_w);
        return 1 << off_w;
    endfunction

    function automatic int num_lines(input int index_w);
        return 1 << index_w;
    endfunction

    localparam int TAG_W          = tag_width(ADDR_W_DEF, INDEX_W_DEF, OFF_W_DEF);
    localparam int WORDS_PER_LINE = words_per_line(OFF_W_DEF);
    localparam int LINES          = num_lines(INDEX_W_DEF);

endpackage : cache_pkg

// File: rtl/param_cache_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset, clears the count
//   inc      count one event this cycle
//   count_o  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule : sat_counter

// File: rtl/param_cache.sv
// -----------------------------------------------------------------------------
// param_cache
// Direct-mapped, read-only word cache with whole-line refill.
// Address decode: cpu_addr = {tag, index, offset}.
// Ports:
//   clk, rst            clock (rising edge) / asynchronous active-low reset
//   cpu_req, cpu_addr   read request, accepted when cpu_req && cpu_ready
//   cpu_ready           high only in IDLE with no flush requested or pending
//   cpu_rvalid, rdata   one-cycle response pulse with the requested word
//   mem_req, mem_addr   line refill request (line-aligned address)
//   mem_rvalid, rdata   refill beats, ascending offset, gaps allowed
//   flush               invalidate every line (deferred if busy)
//   hit_cnt, miss_cnt   saturating statistics
// Hit latency: response is registered out of LOOKUP, so cpu_rvalid is high in
// the cycle that follows the LOOKUP cycle.
// -----------------------------------------------------------------------------
module param_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int OFF_W   = OFF_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int TAG_BITS  = tag_width(ADDR_W, INDEX_W, OFF_W);
    localparam int NUM_WORDS = words_per_line(OFF_W);
    localparam int NUM_LINES = num_lines(INDEX_W);

    generate
        if (TAG_BITS < 1) begin : g_bad_geometry
            $error("param_cache: ADDR_W must exceed INDEX_W + OFF_W");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [OFF_W-1:0]      beat_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic                  flush_pend_q;
    logic                  mem_req_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic                  rvalid_q;
    logic [DATA_W-1:0]     rdata_q;

    // Storage: word array addressed by {index, offset}, tag array by index.
    logic [DATA_W-1:0]     data_mem [0:NUM_LINES*NUM_WORDS-1];
    logic [TAG_BITS-1:0]   tag_mem  [0:NUM_LINES-1];

    // ------------------------------------------------------------------
    // Address decode of the registered request
    // ------------------------------------------------------------------
    logic [TAG_BITS-1:0] req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFF_W-1:0]    req_off;

    assign req_tag   = addr_q[ADDR_W-1 -: TAG_BITS];
    assign req_index = addr_q[OFF_W +: INDEX_W];
    assign req_off   = addr_q[OFF_W-1:0];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic lookup_hit;
    logic beat_fire;
    logic last_beat;
    logic hit_inc;
    logic miss_inc;
    logic accept;

    assign lookup_hit = valid_q[req_index] && (tag_mem[req_index] == req_tag);
    // Beats are only meaningful while refilling; anything else on the bus is dropped.
    assign beat_fire  = (state_q == REFILL) && mem_rvalid;
    assign last_beat  = beat_fire && (beat_q == '1);
    assign hit_inc    = (state_q == LOOKUP) && lookup_hit;
    assign miss_inc   = (state_q == LOOKUP) && !lookup_hit;

    // A flush (live or deferred) owns the IDLE cycle, so no request may slip in.
    assign cpu_ready  = (state_q == IDLE) && !flush && !flush_pend_q;
    assign accept     = cpu_req && cpu_ready;

    // ------------------------------------------------------------------
    // Storage writes
    // ------------------------------------------------------------------
    // NOTE: the data and tag arrays carry no reset; a line is only ever read
    // through its valid bit, which is reset, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            data_mem[{req_index, beat_q}] <= mem_rdata;
        end
        if (last_beat) begin
            tag_mem[req_index] <= req_tag;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            // Response strobe is a single-cycle pulse unless re-armed below.
            rvalid_q <= 1'b0;

            // A flush seen while busy is remembered and served in IDLE, so the
            // in-flight refill still completes and responds.
            if (flush && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (flush || flush_pend_q) begin
                        valid_q      <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (accept) begin
                        addr_q  <= cpu_addr;
                        state_q <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (lookup_hit) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= data_mem[{req_index, req_off}];
                        state_q  <= IDLE;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {req_tag, req_index, {OFF_W{1'b0}}};
                        beat_q     <= '0;
                        state_q    <= REFILL;
                    end
                end

                REFILL: begin
                    if (mem_rvalid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        // Requested word is captured on the fly; no re-read needed.
                        if (beat_q == req_off) begin
                            rdata_q <= mem_rdata;
                        end
                        if (beat_q == '1) begin
                            valid_q[req_index] <= 1'b1;
                            mem_req_q          <= 1'b0;
                            rvalid_q           <= 1'b1;
                            state_q            <= RESPOND;
                        end
                    end
                end

                RESPOND: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (hit_inc),
        .count_o (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (miss_inc),
        .count_o (miss_cnt)
    );

endmodule : param_cache

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 Parameter ADDR_W, 15, word-address width.
REQ-002 Parameter DATA_W, 32, word width.
REQ-003 Parameter INDEX_W, 10, line-index width, giving 2**INDEX_W lines.
REQ-004 Parameter OFF_W, 2, word-offset width, giving 2**OFF_W words per line; tag width TAG_W = ADDR_W-INDEX_W-OFF_W, which SHALL be >= 1.
REQ-005 Parameter CNT_W, 14, statistics counter width.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 cpu_req  in  1  read request, qualified by cpu_ready.
REQ-009 cpu_addr  in  ADDR_W  word address, decoded as {tag, index, offset}.
REQ-010 cpu_ready  out  1  request accepted when cpu_req and cpu_ready are both high at a rising edge.
REQ-011 cpu_rvalid  out  1  one-cycle pulse qualifying cpu_rdata.
REQ-012 cpu_rdata  out  DATA_W  returned word.
REQ-013 mem_req  out  1  line refill request.
REQ-014 mem_addr  out  ADDR_W  line-aligned refill address, offset bits zero.
REQ-015 mem_rvalid  in  1  one refill beat per cycle when high.
REQ-016 mem_rdata  in  DATA_W  refill beat data, ascending offset order.
REQ-017 flush  in  1  invalidate all lines.
REQ-018 hit_cnt, miss_cnt  out  CNT_W  saturating statistics counters.

Function
REQ-019 Direct-mapped organisation, read-only; each line holds a valid bit, a TAG_W tag and 2**OFF_W words.
REQ-020 FSM states: IDLE, LOOKUP, REFILL, RESPOND.
REQ-021 cpu_ready SHALL be high only in IDLE with flush low and no flush pending.
REQ-022 On acceptance, address is registered and FSM moves IDLE->LOOKUP.
REQ-023 LOOKUP hit (line valid and tag equal) -> IDLE; cpu_rvalid and cpu_rdata are registered, giving exactly a 2-cycle latency from the acceptance edge; hit_cnt increments.
REQ-024 LOOKUP miss -> REFILL; miss_cnt increments.
REQ-025 In REFILL, mem_req is held high with mem_addr = {tag, index, 0}; an OFF_W-bit beat counter starting at 0 increments on each mem_rvalid, and each beat is written to the word at that offset.
REQ-026 The beat whose offset equals the requested offset is captured as the response word.
REQ-027 On the final beat, valid is set, the tag is written and FSM moves to RESPOND; mem_req drops on the following cycle.
REQ-028 RESPOND asserts cpu_rvalid for one cycle with the captured word, then moves to IDLE.
REQ-029 mem_rvalid outside REFILL SHALL be ignored.
REQ-030 Gaps in mem_rvalid (low cycles) SHALL stall REFILL without error.
REQ-031 flush in IDLE clears all valid bits at the next edge and takes priority over a same-cycle cpu_req, which is not accepted.
REQ-032 flush outside IDLE sets a pending flag; the flush executes on the first IDLE cycle; the in-flight refill completes and responds normally.
REQ-033 Counters saturate at all-ones and never wrap.
REQ-034 cpu_rvalid is low in every state except on the defined response cycles.

Reset
REQ-035 Reset SHALL force state IDLE, all valid bits 0, flush pending 0, beat counter 0, mem_req 0, cpu_rvalid 0, cpu_rdata 0, mem_addr 0, and both counters 0.
REQ-036 Reset mid-REFILL abandons the refill: no line is marked valid and no response is issued.
REQ-037 Data and tag arrays need no reset.

Structure
REQ-038 Shared package cache_pkg SHALL hold the state enum and derived widths (TAG_W, words-per-line, lines).
REQ-039 One sub-module, sat_counter (CNT_W parameter, inc input), SHALL be instantiated twice, once per statistics counter.

Verification
REQ-040 Defaults; after reset, read 0x0005 -> mem_addr=0x0004, 4 beats A0..A3 with no gaps -> cpu_rvalid with A1, miss_cnt=1.
REQ-041 Read 0x0006 after REQ-040 -> cpu_rvalid exactly 2 cycles after acceptance with A2, hit_cnt=1, mem_req stays low.
REQ-042 Read 0x1004 (same index, different tag) -> miss, refill from 0x1004, later read 0x0004 -> miss again.
REQ-043 flush asserted together with cpu_req in IDLE -> cpu_ready=0 that cycle; next read of 0x0005 misses.
REQ-044 Refill with mem_rvalid pattern 1,0,0,1,1,0,1 -> correct 4 words stored; flush raised mid-refill -> response still delivered, then all lines invalid.
REQ-045 rst low during beat 2 -> mem_req=0, state IDLE, re-read of same address misses; CNT_W=2 with 5 misses -> miss_cnt=3.
